// File: rtl/sub_bytes_seq.sv
// Forward AES SubBytes engine: captures one 128-bit state and substitutes
// LANES bytes per clock through the FIPS-197 S-box, then holds the result.
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] inp,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] outp,
  output logic         busy
);

  localparam int K = 16 / LANES;
  localparam logic [3:0] LAST_PTR = 4'(K - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Entry b sits at bits [8b:8b+7]; row r holds entries 16r..16r+15.
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nxt;
  logic [0:127] work, work_sub;
  logic [3:0]   ptr;
  logic [3:0]   lane_idx;

  always_comb begin
    work_sub = work;
    lane_idx = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_idx = 4'(int'(ptr) * LANES + j);
      work_sub[{lane_idx, 3'b000} +: 8] = sbox(work[{lane_idx, 3'b000} +: 8]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = BUSY;
      BUSY:    if (ptr == LAST_PTR) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          work <= inp;
          ptr  <= '0;
        end
        BUSY: begin
          work <= work_sub;
          ptr  <= ptr + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign outp      = work;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LANES 4, 1, 16) checked against an
// S-box derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_seq;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic         out_ready = 1;
  logic [0:127] inp = '0;
  int           sel = 4;

  logic         rdy4, ov4, bz4, rdy1, ov1, bz1, rdy16, ov16, bz16;
  logic [0:127] o4, o1, o16;
  logic         cur_ready, cur_ovalid, cur_busy;
  logic [0:127] cur_outp;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sbox_m [256];

  localparam logic [0:127] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [0:127] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  always #5 clk = ~clk;

  sub_bytes_seq #(.LANES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 4), .in_ready(rdy4), .inp(inp),
    .out_valid(ov4), .out_ready(out_ready), .outp(o4), .busy(bz4));
  sub_bytes_seq #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(rdy1), .inp(inp),
    .out_valid(ov1), .out_ready(out_ready), .outp(o1), .busy(bz1));
  sub_bytes_seq #(.LANES(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 16), .in_ready(rdy16), .inp(inp),
    .out_valid(ov16), .out_ready(out_ready), .outp(o16), .busy(bz16));

  always_comb begin
    case (sel)
      1:       begin cur_ready = rdy1;  cur_ovalid = ov1;  cur_busy = bz1;  cur_outp = o1;  end
      16:      begin cur_ready = rdy16; cur_ovalid = ov16; cur_busy = bz16; cur_outp = o16; end
      default: begin cur_ready = rdy4;  cur_ovalid = ov4;  cur_busy = bz4;  cur_outp = o4;  end
    endcase
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [0:127] ref_sub(input logic [0:127] d);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m[d[8*i +: 8]];
    return r;
  endfunction

  // Presents one block, returns edges from accept (inclusive) to out_valid and the result.
  task automatic send_block(input logic [0:127] d, output int lat, output logic [0:127] res);
    int w = 0;
    lat = -1;
    res = '0;
    while (!cur_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!cur_ready) return;
    inp = d;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    w = 1;
    while (!cur_ovalid && w < 40) begin @(posedge clk); #1; w++; end
    if (cur_ovalid) begin lat = w; res = cur_outp; end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; sel = 4;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n_vec++;
    if ({cur_ready, cur_ovalid, cur_busy} !== 3'b100 || cur_outp !== '0) begin
      n_err++;
      $display("FAIL reset: ready/valid/busy=%b outp=%h, want 100 and 0",
               {cur_ready, cur_ovalid, cur_busy}, cur_outp);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({cur_ready, cur_ovalid, cur_busy} !== 3'b100 || cur_outp !== '0) begin
        n_err++;
        $display("FAIL idle_hold cycle %0d: ready/valid/busy=%b outp=%h, want 100 and 0",
                 c, {cur_ready, cur_ovalid, cur_busy}, cur_outp);
      end
    end
  endtask

  task automatic test_fips();
    int lat; logic [0:127] res;
    sel = 4; out_ready = 1;
    send_block(FIPS_IN, lat, res);
    n_vec++;
    if (lat !== 5) begin n_err++; $display("FAIL fips_latency: got %0d want 5", lat); end
    n_vec++;
    if (res !== FIPS_OUT) begin n_err++; $display("FAIL fips_data: got %h want %h", res, FIPS_OUT); end
    n_vec++;
    if (res !== ref_sub(FIPS_IN)) begin n_err++; $display("FAIL fips_model: got %h want %h", res, ref_sub(FIPS_IN)); end
    @(posedge clk); #1;
    n_vec++;
    if (cur_ovalid !== 1'b0 || cur_ready !== 1'b1) begin
      n_err++;
      $display("FAIL fips_pulse: out_valid=%b in_ready=%b want 0 1", cur_ovalid, cur_ready);
    end
  endtask

  task automatic test_corners();
    int lat; logic [0:127] res;
    logic [0:127] a = {4{32'h0001_53ff}};
    logic [0:127] e = {4{32'h637c_ed16}};
    sel = 4; out_ready = 1;
    send_block(a, lat, res);
    n_vec++;
    if (res !== e) begin n_err++; $display("FAIL corner_bytes: got %h want %h", res, e); end
    @(posedge clk); #1;
    send_block('0, lat, res);
    n_vec++;
    if (res !== {16{8'h63}}) begin n_err++; $display("FAIL all_zero: got %h want all 63", res); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [0:127] d, res;
    sel = 4; out_ready = 1;
    for (int n = 0; n < 8; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send_block(d, lat, res);
      n_vec++;
      if (res !== ref_sub(d) || lat !== 5) begin
        n_err++;
        $display("FAIL random %0d: in %h got %h lat %0d want %h lat 5", n, d, res, lat, ref_sub(d));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [0:127] d, d2, res, held;
    int bad = 0;
    sel = 4; out_ready = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send_block(d, lat, held);
    n_vec++;
    if (held !== ref_sub(d)) begin n_err++; $display("FAIL bp_data: got %h want %h", held, ref_sub(d)); end
    d2 = ~d;
    inp = d2; in_valid = 1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (cur_outp !== held || cur_ready !== 1'b0 || cur_ovalid !== 1'b1) bad++;
    end
    in_valid = 0;
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
    out_ready = 1;
    @(posedge clk); #1;
    n_vec++;
    if (cur_ready !== 1'b1 || cur_ovalid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", cur_ready, cur_ovalid);
    end
    send_block(d2, lat, res);
    n_vec++;
    if (res !== ref_sub(d2)) begin n_err++; $display("FAIL bp_next: got %h want %h", res, ref_sub(d2)); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; int seen = 0; logic [0:127] d, res;
    sel = 4; out_ready = 1;
    inp = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    n_vec++;
    if ({cur_ready, cur_ovalid, cur_busy} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_mid_state: ready/valid/busy=%b want 100", {cur_ready, cur_ovalid, cur_busy});
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (cur_ovalid) seen++;
    end
    n_vec++;
    if (seen != 0) begin n_err++; $display("FAIL reset_mid_pulse: %0d out_valid cycles want 0", seen); end
    d = {$urandom, $urandom, $urandom, $urandom};
    send_block(d, lat, res);
    n_vec++;
    if (res !== ref_sub(d)) begin n_err++; $display("FAIL reset_mid_next: got %h want %h", res, ref_sub(d)); end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat; logic [0:127] res;
    out_ready = 1;
    sel = 1;
    send_block(FIPS_IN, lat, res);
    n_vec++;
    if (lat !== 17 || res !== FIPS_OUT) begin
      n_err++;
      $display("FAIL lanes1: got %h lat %0d want %h lat 17", res, lat, FIPS_OUT);
    end
    @(posedge clk); #1;
    sel = 16;
    send_block(FIPS_IN, lat, res);
    n_vec++;
    if (lat !== 2 || res !== FIPS_OUT) begin
      n_err++;
      $display("FAIL lanes16: got %h lat %0d want %h lat 2", res, lat, FIPS_OUT);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lanes [3] = '{4, 1, 16};
    int k, cyc, last, nacc;
    logic acc;
    logic [0:127] d;
    out_ready = 1;
    for (int s = 0; s < 3; s++) begin
      sel = lanes[s];
      k = 16 / lanes[s];
      d = {$urandom, $urandom, $urandom, $urandom};
      inp = d; in_valid = 1;
      cyc = 0; last = -1; nacc = 0;
      for (int c = 0; c < 4 * (k + 2); c++) begin
        acc = cur_ready;
        @(posedge clk); #1; cyc++;
        if (acc) begin
          if (last >= 0) begin
            n_vec++;
            if (cyc - last != k + 2) begin
              n_err++;
              $display("FAIL b2b_period lanes %0d: got %0d want %0d", lanes[s], cyc - last, k + 2);
            end
          end
          last = cyc; nacc++;
        end
        if (cur_ovalid) begin
          n_vec++;
          if (cur_outp !== ref_sub(d)) begin
            n_err++;
            $display("FAIL b2b_data lanes %0d: got %h want %h", lanes[s], cur_outp, ref_sub(d));
          end
        end
      end
      in_valid = 0;
      n_vec++;
      if (nacc < 3) begin n_err++; $display("FAIL b2b_count lanes %0d: got %0d accepts want >=3", lanes[s], nacc); end
      repeat (k + 3) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_corners();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Forward AES SubBytes engine for the encrypt datapath. It is the counterpart of the decrypt-side inverse substitution stage.
- Accepts one 128-bit state through a valid/ready handshake and substitutes every byte through the FIPS-197 forward S-box, LANES bytes per clock.
- Presents the result on a held valid/ready output port.
- Sits between AddRoundKey and ShiftRows in the iterative encrypt round loop.

Parameters:
- LANES, 4, number of S-box lookups per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- K (derived localparam), 16/LANES, number of substitution cycles per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  inp holds a valid state
- in_ready  output  1  block can accept a state
- inp  input  [0:127]  state in; byte i = inp[8i:8i+7], i = 4*row+col (inp[0:7] = s00, inp[120:127] = s33)
- out_valid  output  1  outp holds the substituted state
- out_ready  input  1  downstream accepts outp
- outp  output  [0:127]  substituted state, same byte mapping as inp
- busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (rst=1 at a rising edge): state goes to IDLE; internal state register, counter and outp cleared to 0; out_valid=0; busy=0. in_ready=1 from the first cycle after reset. rst dominates all other inputs, including mid-block: the block in flight is discarded and no out_valid pulse is produced.
- FSM states are IDLE, BUSY and DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE).
- IDLE:
  - On in_valid && in_ready at edge N, capture inp into the working register, clear the 4-bit counter ptr, and go to BUSY.
  - in_valid while not in IDLE is ignored; the source must hold it.
- BUSY:
  - Each cycle, lanes j=0..LANES-1 replace byte i = ptr*LANES + j with SBOX(byte i), in place. All other bytes are unchanged.
  - ptr increments after each cycle.
  - On the cycle where ptr == K-1, perform the final substitution and go to DONE.
  - Processing cycles are edges N+1 .. N+K. out_valid is high from the cycle after edge N+K, giving latency K+1 edges from accept to out_valid (LANES=4: 5 edges).
- DONE:
  - outp is driven directly from the working register and is stable while out_valid=1.
  - On out_valid && out_ready, go to IDLE; in_ready=1 on the next cycle.
  - out_ready=0 holds DONE indefinitely with outp unchanged.
- Accept is not allowed in the same cycle as output handoff. Minimum block period is K+2 cycles.
- SBOX is the FIPS-197 forward S-box, a 256-entry constant lookup, purely combinational per lane. Each lane uses the same table. Examples: 00->63, 01->7c, 53->ed, ff->16, 63->fb.
- No registered pipeline inside the S-box; one lookup per lane per cycle.
- outp value during IDLE/BUSY is don't-care for consumers; the bench checks it only under out_valid.
- Byte order is never reversed: byte 0 always occupies bits [0:7].

Test Plan:
- Reset then idle: after rst, in_ready=1, out_valid=0, busy=0, outp=0; hold 10 cycles with in_valid=0 -> nothing changes.
- FIPS-197 vector: inp=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_valid rises exactly 5 edges after accept (LANES=4), outp=d42711aee0bf98f1b8b45de51e415230, one-cycle out_valid pulse, in_ready back next cycle.
- Corner bytes: inp=00 01 53 ff repeated four times -> outp=63 7c ed 16 repeated; inp all 00 -> all 63.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> outp stable, in_ready=0 throughout, a new in_valid is not accepted; raising out_ready completes the handoff and the next block is then accepted correctly.
- Reset mid-operation: assert rst on the 2nd BUSY cycle -> next cycle IDLE, out_valid never pulses, and a following block produces the correct result.
- Parameter sweep: LANES=1 and LANES=16 with the FIPS-197 vector -> identical outp, latency 17 and 2 edges respectively; back-to-back blocks with continuous in_valid give a period of K+2 cycles.
